// File: rtl/match_search_arbiter_if.sv
// ---------------------------------------------------------------------------
// match_search_arbiter_if
//   Bundles the requester handshake and the match-engine handshake seen by
//   match_search_arbiter.
//   master : client/engine side; drives req, eng_done and eng_location.
//   slave  : arbiter side; drives eng_start, grant, ack, result_valid,
//            result_loc and result_err.
// ---------------------------------------------------------------------------
interface match_search_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 9
);
    logic [NREQ-1:0] req;
    logic            eng_done;
    logic [AW-1:0]   eng_location;
    logic            eng_start;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            result_valid;
    logic [AW-1:0]   result_loc;
    logic            result_err;

    modport master (
        output req, eng_done, eng_location,
        input  eng_start, grant, ack, result_valid, result_loc, result_err
    );

    modport slave (
        input  req, eng_done, eng_location,
        output eng_start, grant, ack, result_valid, result_loc, result_err
    );
endinterface

// File: rtl/match_search_arbiter.sv
// ---------------------------------------------------------------------------
// match_search_arbiter
//   Shares one pattern-match engine among NREQ requesters. A round-robin
//   arbiter picks a requester, pulses eng_start, waits for eng_done (or a
//   watchdog timeout), captures the match location and acks the owner.
//
//   Ports:
//     clock  : system clock
//     reset  : asynchronous, active-low
//     bus    : match_search_arbiter_if.slave
//              in : req[NREQ], eng_done, eng_location[AW]
//              out: eng_start, grant[NREQ] (one-hot owner), ack[NREQ],
//                   result_valid, result_loc[AW], result_err
//   All outputs are registered.
// ---------------------------------------------------------------------------
module match_search_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    match_search_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0]  NREQ_W    = (IW+1)'(NREQ);
    localparam logic [15:0]  TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   winner;
    logic [15:0]     timer;
    logic            eng_start;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            result_valid;
    logic [AW-1:0]   result_loc;
    logic            result_err;

    // Round-robin pick: first set req bit at last_winner+1, +2, ... mod NREQ.
    logic [IW-1:0]   pick;
    logic            found;
    logic [IW:0]     rr_sum;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        pick   = last_winner;
        found  = 1'b0;
        rr_sum = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_sum = {1'b0, last_winner} + (IW+1)'(i);
            if (rr_sum >= NREQ_W) rr_sum = rr_sum - NREQ_W;
            if (!found && bus.req[rr_sum[IW-1:0]]) begin
                pick  = rr_sum[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // Saturating increment; abort fires on the BUSY cycle the count reaches TIMEOUT.
    logic [15:0] timer_next;
    assign timer_next = (timer == 16'hFFFF) ? timer : timer + 16'd1;

    // NOTE: sequential state uses non-blocking assignments and an async reset;
    // pulse outputs default low each cycle and are raised only on state entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_winner  <= IW'(NREQ - 1);
            winner       <= '0;
            timer        <= '0;
            eng_start    <= 1'b0;
            grant        <= '0;
            ack          <= '0;
            result_valid <= 1'b0;
            result_loc   <= '0;
            result_err   <= 1'b0;
        end else begin
            eng_start    <= 1'b0;
            ack          <= '0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        winner    <= pick;
                        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        eng_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    // eng_done is ignored here; the engine has not seen start yet.
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    timer <= timer_next;
                    // Done is checked first so a tie with the timeout is a success.
                    if (bus.eng_done || timer_next >= TIMEOUT_W) begin
                        result_loc   <= bus.eng_done ? bus.eng_location : '0;
                        result_err   <= !bus.eng_done;
                        ack          <= grant;
                        result_valid <= 1'b1;
                        grant        <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    last_winner <= winner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.eng_start    = eng_start;
    assign bus.grant        = grant;
    assign bus.ack          = ack;
    assign bus.result_valid = result_valid;
    assign bus.result_loc   = result_loc;
    assign bus.result_err   = result_err;
endmodule

// File: tb/tb_match_search_arbiter.sv
// ---------------------------------------------------------------------------
// tb_match_search_arbiter
//   Directed bench for match_search_arbiter (NREQ=4, AW=9, TIMEOUT=8).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_match_search_arbiter;
    localparam int NREQ    = 4;
    localparam int AW      = 9;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    match_search_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus();

    match_search_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".grant"},  32'(bus.grant), 0);
        check({tag, ".ack"},    32'(bus.ack), 0);
        check({tag, ".start"},  32'(bus.eng_start), 0);
        check({tag, ".valid"},  32'(bus.result_valid), 0);
        check({tag, ".loc"},    32'(bus.result_loc), 0);
        check({tag, ".err"},    32'(bus.result_err), 0);
    endtask

    // One full search. Entered on a falling edge with the DUT in IDLE.
    // done_at: falling edge (0 = START) where eng_done is driven for one
    // cycle; -1 = never. exp_cycles: falling edges from START to RESP.
    task automatic search(input string tag, input logic [3:0] req_v, input logic [3:0] drop,
                          input int done_at, input logic [8:0] loc,
                          input logic [3:0] exp_grant, input int exp_cycles,
                          input logic exp_err, input logic [8:0] exp_loc, input bit keep_req);
        int cur;
        int starts;
        bus.req = req_v;
        @(negedge clock);
        check({tag, ".start"}, 32'(bus.eng_start), 1);
        check({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        cur    = 0;
        starts = 0;
        while (cur < 20 && bus.ack == '0) begin
            if (cur == done_at) begin
                bus.eng_done     = 1'b1;
                bus.eng_location = loc;
            end
            if (cur == 1) bus.req = bus.req & ~drop;
            @(negedge clock);
            cur++;
            bus.eng_done = 1'b0;
            if (bus.eng_start) starts++;
            if (cur == 1) check({tag, ".grant_busy"}, 32'(bus.grant), 32'(exp_grant));
        end
        check({tag, ".cycles"}, cur, exp_cycles);
        check({tag, ".ack"},    32'(bus.ack), 32'(exp_grant));
        check({tag, ".valid"},  32'(bus.result_valid), 1);
        check({tag, ".loc"},    32'(bus.result_loc), 32'(exp_loc));
        check({tag, ".err"},    32'(bus.result_err), 32'(exp_err));
        check({tag, ".extra_start"}, starts, 0);
        if (!keep_req) bus.req = '0;
        @(negedge clock);
        check({tag, ".ack_off"},   32'(bus.ack), 0);
        check({tag, ".valid_off"}, 32'(bus.result_valid), 0);
        check({tag, ".grant_off"}, 32'(bus.grant), 0);
        check({tag, ".loc_hold"},  32'(bus.result_loc), 32'(exp_loc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req          = '0;
        bus.eng_done     = 1'b0;
        bus.eng_location = '0;
        #3 reset = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // T2 fairness: all four requesting, done two cycles after each start.
        search("T2a", 4'b1111, 4'b0000, 2, 9'd11, 4'b0001, 3, 1'b0, 9'd11, 1'b1);
        search("T2b", 4'b1111, 4'b0000, 2, 9'd12, 4'b0010, 3, 1'b0, 9'd12, 1'b1);
        search("T2c", 4'b1111, 4'b0000, 2, 9'd13, 4'b0100, 3, 1'b0, 9'd13, 1'b1);
        search("T2d", 4'b1111, 4'b0000, 2, 9'd14, 4'b1000, 3, 1'b0, 9'd14, 1'b1);
        search("T2e", 4'b1111, 4'b0000, 2, 9'd15, 4'b0001, 3, 1'b0, 9'd15, 1'b0);

        // T1 single requester, done 5 cycles after start.
        search("T1", 4'b0010, 4'b0000, 5, 9'd37, 4'b0010, 6, 1'b0, 9'd37, 1'b0);

        // T3 timeout: no done, abort after 8 BUSY cycles.
        search("T3", 4'b0100, 4'b0000, -1, 9'd99, 4'b0100, 9, 1'b1, 9'd0, 1'b0);

        // T4 tie: done on the 8th BUSY cycle wins over the timeout.
        search("T4", 4'b0001, 4'b0000, 8, 9'h1FF, 4'b0001, 9, 1'b0, 9'h1FF, 1'b0);

        // T6 drop: req[3] removed during BUSY, ack still delivered.
        search("T6", 4'b1000, 4'b1000, 3, 9'd100, 4'b1000, 4, 1'b0, 9'd100, 1'b0);

        // Spurious eng_done while IDLE must be ignored.
        bus.eng_done     = 1'b1;
        bus.eng_location = 9'd7;
        @(negedge clock);
        check("idle_done.ack",   32'(bus.ack), 0);
        check("idle_done.valid", 32'(bus.result_valid), 0);
        check("idle_done.start", 32'(bus.eng_start), 0);
        @(negedge clock);
        bus.eng_done = 1'b0;
        check("idle_done.grant", 32'(bus.grant), 0);
        check("idle_done.loc",   32'(bus.result_loc), 100);

        // T5 reset mid-BUSY (last winner is 3, so req 0110 grants bit 1).
        bus.req = 4'b0110;
        @(negedge clock);
        check("T5.grant", 32'(bus.grant), 32'(4'b0010));
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_outputs_zero("T5.async");
        bus.req = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("T5.no_ack", 32'(bus.ack), 0);
        end
        reset = 1'b1;
        search("T5a", 4'b1001, 4'b0000, 1, 9'd2, 4'b0001, 2, 1'b0, 9'd2, 1'b1);
        // Requester 0 still asserting drops to lowest priority.
        search("T5b", 4'b1001, 4'b0000, 1, 9'd5, 4'b1000, 2, 1'b0, 9'd5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
